param_counter: RTL and testbench



---
 rtl/param_counter_pkg.sv | 16 +
 rtl/param_counter_fsm.sv | 58 +++++
 rtl/param_counter.sv | 93 +++++++++
 tb/tb_param_counter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/param_counter_pkg.sv
// Shared types and helpers for the modulo-N up/down counter.
// Holds the FSM state encoding and the direction-dependent terminal value.
package param_counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Terminal value of a count in the given direction; the caller narrows it to its own width.
  function automatic longint terminal_val(input logic up, input longint modulus);
    return up ? (modulus - 1) : 64'sd0;
  endfunction

endpackage

// File: rtl/param_counter_fsm.sv
// IDLE/RUN/DONE sequencer for the counter.
// It owns the wrap and busy registers. Latency 1. There is no backpressure; en only stalls the count.
module param_counter_fsm
  import param_counter_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic oneshot,
  input  logic start,
  input  logic en,
  input  logic at_terminal,
  input  logic load,
  output logic count_en,
  output logic wrap,
  output logic busy
);

  state_e state;
  state_e state_nxt;
  logic   wrap_nxt;
  logic   step_req;

  always_comb begin
    state_nxt = state;
    wrap_nxt  = 1'b0;
    count_en  = 1'b0;
    // Any load strobe, even an ignored out-of-range one, suppresses the step and any wrap.
    step_req  = en && !load;

    if (!oneshot) begin
      state_nxt = IDLE;
      count_en  = step_req;
      wrap_nxt  = step_req && at_terminal;
    end else if (start) begin
      state_nxt = RUN;
    end else if ((state == RUN) && step_req) begin
      if (at_terminal) begin
        state_nxt = DONE;
        wrap_nxt  = 1'b1;
      end else begin
        count_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      wrap  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      wrap  <= wrap_nxt;
      busy  <= (state_nxt == RUN);
    end
  end

endmodule

// File: rtl/param_counter.sv
// Parametrised modulo-MODULUS up/down counter with load, enable and one-shot mode. Latency 1. No backpressure.
// The PCOUNTER_LOAD_CLAMP_EN macro makes an out-of-range load clamp to MODULUS-1 instead of being ignored.
module param_counter
  import param_counter_pkg::*;
#(
  parameter int     WIDTH   = 4,
  parameter longint MODULUS = 16
)
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             oneshot,
  input  logic             start,
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic             busy
);

  localparam logic [WIDTH:0] MAX_VAL = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH:0] ONE     = (WIDTH+1)'(1);

  logic [WIDTH:0] q_ext;
  logic [WIDTH:0] term_ext;
  logic [WIDTH:0] start_ext;
  logic [WIDTH:0] step_ext;
  logic [WIDTH:0] load_ext;
  logic [WIDTH:0] q_nxt_ext;
  logic           at_terminal;
  logic           load_ok;
  logic           count_en;

  // One extra bit of headroom lets MODULUS reach 2**WIDTH without overflowing the compare.
  always_comb begin
    q_ext       = {1'b0, q};
    term_ext    = (WIDTH+1)'(terminal_val(up, MODULUS));
    start_ext   = up ? '0 : MAX_VAL;
    at_terminal = (q_ext == term_ext);

    if (at_terminal) begin
      step_ext = start_ext;
    end else if (up) begin
      step_ext = q_ext + ONE;
    end else begin
      step_ext = q_ext - ONE;
    end

`ifdef PCOUNTER_LOAD_CLAMP_EN
    load_ok  = load;
    load_ext = ({1'b0, load_val} > MAX_VAL) ? MAX_VAL : {1'b0, load_val};
`else
    load_ok  = load && ({1'b0, load_val} <= MAX_VAL);
    load_ext = {1'b0, load_val};
`endif

    if (load_ok) begin
      q_nxt_ext = load_ext;
    end else if (oneshot && start) begin
      q_nxt_ext = start_ext;
    end else if (count_en) begin
      q_nxt_ext = step_ext;
    end else begin
      q_nxt_ext = q_ext;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else begin
      q <= WIDTH'(q_nxt_ext);
    end
  end

  param_counter_fsm u_fsm (
    .clk         (clk),
    .reset_n     (reset_n),
    .oneshot     (oneshot),
    .start       (start),
    .en          (en),
    .at_terminal (at_terminal),
    .load        (load),
    .count_en    (count_en),
    .wrap        (wrap),
    .busy        (busy)
  );

  a_q_in_range: assert property (@(posedge clk) disable iff (!reset_n) ({1'b0, q} <= MAX_VAL));

endmodule

// File: tb/tb_param_counter.sv
// Self-checking bench for param_counter at WIDTH=4, MODULUS=10.
// It uses a vector table, hand-written one-shot and reset sequences, and random stimulus checked against a reference model.
module tb_param_counter;
  localparam int W = 4;
  localparam int M = 10;
`ifdef PCOUNTER_LOAD_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         en = 1'b0;
  logic         up = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         oneshot = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] q;
  logic         wrap;
  logic         busy;

  int checks = 0;
  int failures = 0;

  // Reference model state: mstate 0=idle, 1=running, 2=done.
  int mq = 0;
  int mstate = 0;
  bit mwrap = 1'b0;

  typedef struct {
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] lv;
    int         q;
    logic       wr;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  param_counter #(.WIDTH(W), .MODULUS(M)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .oneshot  (oneshot),
    .start    (start),
    .q        (q),
    .wrap     (wrap),
    .busy     (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_update();
    int term;
    int sv;
    int lv;
    bit ldok;
    term  = up ? M - 1 : 0;
    sv    = up ? 0 : M - 1;
    lv    = (int'(load_val) >= M) ? M - 1 : int'(load_val);
    ldok  = load && (CLAMP || int'(load_val) < M);
    mwrap = 1'b0;
    if (!oneshot) begin
      mstate = 0;
      if (ldok) mq = lv;
      else if (en && !load) begin
        if (mq == term) mwrap = 1'b1;
        mq = up ? (mq + 1) % M : (mq + M - 1) % M;
      end
    end else if (start) begin
      mstate = 1;
      mq = ldok ? lv : sv;
    end else if (ldok) begin
      mq = lv;
    end else if (en && !load && mstate == 1) begin
      if (mq == term) begin
        mstate = 2;
        mwrap  = 1'b1;
      end else begin
        mq = up ? (mq + 1) % M : (mq + M - 1) % M;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic add_vec(input logic e, input logic u, input logic l, input logic [3:0] v,
                         input int eq, input logic ew);
    vec_t t;
    t.en = e; t.up = u; t.load = l; t.lv = v; t.q = eq; t.wr = ew;
    vecs.push_back(t);
  endtask

  initial begin
    // Free-run up for 12 cycles from 0: q=1..9, then 0 with wrap, then 1, 2.
    for (int i = 0; i < 12; i++) add_vec(1, 1, 0, 0, (i + 1) % M, i == 9);
    add_vec(1, 1, 1, 0, 0, 0);   // load 0 overrides the step
    add_vec(1, 0, 0, 0, 9, 1);   // down from 0 wraps to 9
    add_vec(1, 0, 0, 0, 8, 0);
    add_vec(1, 1, 0, 0, 9, 0);   // flip to up at 8: reaches 9 with no wrap
    add_vec(1, 1, 0, 0, 0, 1);
    add_vec(0, 1, 0, 0, 0, 0);   // en low freezes q
    add_vec(1, 1, 1, 9, 9, 0);
    add_vec(1, 1, 1, 4, 4, 0);   // load with en at terminal: load wins, no wrap
    add_vec(1, 1, 1, 12, CLAMP ? 9 : 4, 0);
    add_vec(1, 1, 0, 0, CLAMP ? 0 : 5, CLAMP);

    #3;
    check("reset q", q, 0);
    check("reset wrap", wrap, 0);
    check("reset busy", busy, 0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      en = vecs[i].en; up = vecs[i].up; load = vecs[i].load; load_val = vecs[i].lv;
      tick();
      check($sformatf("vec%0d q", i), q, vecs[i].q);
      check($sformatf("vec%0d wrap", i), wrap, vecs[i].wr);
      check($sformatf("vec%0d busy", i), busy, 0);
    end
    load = 1'b0;

    // One-shot up: start, count 0..9, hold 9, then complete with wrap and busy falling together.
    oneshot = 1'b1; start = 1'b1; en = 1'b1; up = 1'b1;
    tick();
    check("os start q", q, 0);
    check("os start busy", busy, 1);
    start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      check($sformatf("os run q%0d", k), q, k);
      check($sformatf("os run busy%0d", k), busy, 1);
      check($sformatf("os run wrap%0d", k), wrap, 0);
    end
    tick();
    check("os done q", q, 9);
    check("os done wrap", wrap, 1);
    check("os done busy", busy, 0);
    tick();
    check("os hold q", q, 9);
    check("os hold wrap", wrap, 0);
    start = 1'b1;
    tick();
    check("os restart q", q, 0);
    check("os restart busy", busy, 1);
    start = 1'b0;

    // Dropping oneshot mid-run returns to idle and keeps counting in free-run.
    oneshot = 1'b0;
    tick();
    check("os->free q", q, 1);
    check("os->free busy", busy, 0);

    // Simultaneous load and start in idle: run from 5 and complete at 9.
    oneshot = 1'b1; load = 1'b1; load_val = 4'd5; start = 1'b1;
    tick();
    check("ld+st q", q, 5);
    check("ld+st busy", busy, 1);
    load = 1'b0; start = 1'b0;
    for (int k = 6; k <= 9; k++) begin
      tick();
      check($sformatf("ld+st run q%0d", k), q, k);
      check($sformatf("ld+st run busy%0d", k), busy, 1);
    end
    tick();
    check("ld+st done wrap", wrap, 1);
    check("ld+st done busy", busy, 0);
    check("ld+st done q", q, 9);

    // Random stimulus against the reference model.
    for (int c = 0; c < 600; c++) begin
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 7) == 0) up = ~up;
      start = 1'b0;
      load = 1'b0;
      if (en) begin
        if ($urandom_range(0, 15) == 0) oneshot = ~oneshot;
        start = ($urandom_range(0, 9) == 0);
        load = ($urandom_range(0, 11) == 0);
        load_val = W'($urandom_range(0, 15));
      end
      tick();
      check($sformatf("rand%0d q", c), q, mq);
      check($sformatf("rand%0d wrap", c), wrap, mwrap);
      check($sformatf("rand%0d busy", c), busy, mstate == 1);
    end

    // Asynchronous reset mid-count at q=7 clears everything before the next edge.
    oneshot = 1'b1; start = 1'b1; en = 1'b1; up = 1'b1; load = 1'b0;
    tick();
    start = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    check("pre-reset q", q, 7);
    check("pre-reset busy", busy, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset q", q, 0);
    check("async reset wrap", wrap, 0);
    check("async reset busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
